net_tx_arbiter: RTL and testbench
=================================

// Module: net_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 16-bit NI transmit port between N on-GPU packet sources.
//  - Packet format: {dest_gpu[5:0], payload[9:0]}.
//  - Sits between GPU-internal requesters and the NoC network interface (net_data_out/net_valid_out/net_ready_in).
//  - Holds the granted packet until the NI accepts it; drops it on stall timeout.
// PARAMETERS
//  GPU_ID     22    local GPU identifier (6-bit); used only by loopback
//  N_REQ      4     number of requesters, 2..16
//  TIMEOUT    255   net_ready_in-low cycles tolerated while holding a packet; 0 = never drop
//  GRANT_W    $clog2(N_REQ)  grant index width (localparam)
// PORTS
//  ACLK           in   1         clock, rising edge
//  ARESETn        in   1         asynchronous active-low reset
//  req_valid      in   N_REQ     per-requester packet valid
//  req_data       in   16*N_REQ  packets; requester i at [16*i+15:16*i]
//  req_ready      out  N_REQ     one-hot accept strobe (combinational)
//  net_data_out   out  16        packet to NI
//  net_valid_out  out  1         packet valid to NI
//  net_ready_in   in   1         NI accept
//  lb_data_out    out  16        local loopback packet
//  lb_valid_out   out  1         loopback valid
//  lb_ready_in    in   1         loopback accept
//  grant_id       out  GRANT_W   index of last granted requester
//  busy           out  1         1 while in S_HOLD
//  err_timeout    out  1         1-cycle pulse when a held packet is dropped
//  drop_count     out  16        saturating count of dropped packets
// BEHAVIOUR
//  Reset (async, ARESETn=0):
//  - All outputs 0; rr_ptr=0; stall counter 0; state S_IDLE.
//  - Reset mid-hold discards the held packet; no err_timeout pulse.
//  FSM S_IDLE:
//  - If |req_valid: winner = first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//  - req_ready[winner]=1 in that same cycle; that cycle is the transfer.
//  - Register req_data[winner] into the output, assert the selected valid next cycle.
//  - grant_id<=winner; rr_ptr<=(winner+1) mod N_REQ; go S_HOLD.
//  - req_ready is 0 for all bits in S_HOLD and whenever req_valid==0.
//  FSM S_HOLD:
//  - Data/valid stable until accept.
//  - Accept (ready_in=1 on the active port): valid<=0, stall<=0, go S_IDLE.
//  - Otherwise stall++. When TIMEOUT!=0 and stall==TIMEOUT-1 with ready low: drop (valid<=0),
//    err_timeout<=1 for one cycle, drop_count++ (saturates at 16'hFFFF), go S_IDLE.
//  - Accept and timeout in the same cycle: accept wins, no drop.
//  - Packet is never re-sent after a drop.
//  Throughput and latency:
//  - Max 1 packet per 2 cycles.
//  - req handshake to valid_out: 1 cycle.
//  Fairness:
//  - A requester holding valid is granted within N_REQ grants.
//  - Requesters that drop valid before grant lose nothing (no state kept per requester).
//  - Data outputs keep their last value after a transfer (not cleared).
// CONFIGURATION
//  LOCAL_LOOPBACK_EN defined:
//  - Granted packet with data[15:10]==GPU_ID goes to lb_* instead of net_*.
//  - S_HOLD then uses lb_ready_in; timeout rules are identical.
//  - net_valid_out stays 0 for that packet.
//  LOCAL_LOOPBACK_EN undefined:
//  - All packets go to net_*.
//  - lb_data_out, lb_valid_out tied 0; lb_ready_in ignored.
// TESTING
//  1. Reset, req_valid=4'b0001, data0=16'h5D23 (dest 23), net_ready_in=1 -> req_ready=0001 same cycle; net_data_out=5D23, valid 1 cycle later; busy 1 cycle; grant_id=0.
//  2. All 4 requesters valid continuously, ready=1 -> grant order 0,1,2,3,0; one packet per 2 cycles; no requester skipped.
//  3. Hold packet with net_ready_in=0, TIMEOUT=4 -> err_timeout pulse after 4 stall cycles; drop_count=1; valid=0; next requester granted.
//  4. Accept on exact timeout cycle -> transfer completes; err_timeout=0; drop_count unchanged.
//  5. ARESETn low during S_HOLD -> all outputs 0 immediately; after release, next grant starts from requester 0.
//  6. LOCAL_LOOPBACK_EN, data=16'h5800 (dest 22) -> lb_valid_out=1, lb_data_out=5800, net_valid_out stays 0; undefined macro -> net path.

Source files
------------

// File: rtl/net_tx_arbiter.sv
// Round-robin arbiter sharing one 16-bit NI transmit port among N_REQ sources.
// Optional local loopback path enabled by defining LOCAL_LOOPBACK_EN.
module net_tx_arbiter #(
  parameter int GPU_ID  = 22,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255,
  localparam int GRANT_W = $clog2(N_REQ)
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [15:0]          net_data_out,
  output logic                 net_valid_out,
  input  logic                 net_ready_in,
  output logic [15:0]          lb_data_out,
  output logic                 lb_valid_out,
  input  logic                 lb_ready_in,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [15:0]          drop_count
);

  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STALL_LAST =
    SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [5:0] GPU6 = GPU_ID[5:0];

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [GRANT_W-1:0] rr_q, rr_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [SW-1:0]      stall_q, stall_d;
  logic [15:0]        net_data_q, net_data_d;
  logic               net_valid_q, net_valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [15:0]        drop_q, drop_d;

  logic               win_found;
  logic [GRANT_W-1:0] win_idx;
  logic [15:0]        win_data;
  logic               accept;
  int                 idx;

`ifdef LOCAL_LOOPBACK_EN
  logic [15:0] lb_data_q, lb_data_d;
  logic        lb_valid_q, lb_valid_d;
  logic        to_lb_q, to_lb_d;
`else
  logic        unused_lb;
  assign unused_lb = lb_ready_in | (^GPU6);
`endif

  // Scan from rr_q upward, wrapping, for the first valid requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = GRANT_W'(idx);
      end
    end
  end

  assign win_data = req_data[int'(win_idx)*16 +: 16];

  always_comb begin
    req_ready = '0;
    if (ARESETn && state_q == S_IDLE && win_found)
      req_ready[win_idx] = 1'b1;
  end

`ifdef LOCAL_LOOPBACK_EN
  assign accept = to_lb_q ? lb_ready_in : net_ready_in;
`else
  assign accept = net_ready_in;
`endif

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    stall_d     = stall_q;
    net_data_d  = net_data_q;
    net_valid_d = net_valid_q;
    busy_d      = busy_q;
    err_d       = 1'b0;
    drop_d      = drop_q;
`ifdef LOCAL_LOOPBACK_EN
    lb_data_d   = lb_data_q;
    lb_valid_d  = lb_valid_q;
    to_lb_d     = to_lb_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          rr_d    = (win_idx == GRANT_W'(N_REQ - 1)) ?
                    '0 : win_idx + 1'b1;
          stall_d = '0;
          busy_d  = 1'b1;
          state_d = S_HOLD;
`ifdef LOCAL_LOOPBACK_EN
          to_lb_d = (win_data[15:10] == GPU6);
          if (win_data[15:10] == GPU6) begin
            lb_data_d  = win_data;
            lb_valid_d = 1'b1;
          end else begin
            net_data_d  = win_data;
            net_valid_d = 1'b1;
          end
`else
          net_data_d  = win_data;
          net_valid_d = 1'b1;
`endif
        end
      end
      S_HOLD: begin
        // Accept has priority over a same-cycle timeout.
        if (accept || (TO_EN && stall_q == STALL_LAST)) begin
          net_valid_d = 1'b0;
`ifdef LOCAL_LOOPBACK_EN
          lb_valid_d  = 1'b0;
`endif
          stall_d = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (!accept) begin
            err_d  = 1'b1;
            drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
          end
        end else if (TO_EN) begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      stall_q     <= '0;
      net_data_q  <= '0;
      net_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= '0;
`ifdef LOCAL_LOOPBACK_EN
      lb_data_q   <= '0;
      lb_valid_q  <= 1'b0;
      to_lb_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      stall_q     <= stall_d;
      net_data_q  <= net_data_d;
      net_valid_q <= net_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
`ifdef LOCAL_LOOPBACK_EN
      lb_data_q   <= lb_data_d;
      lb_valid_q  <= lb_valid_d;
      to_lb_q     <= to_lb_d;
`endif
    end
  end

  assign net_data_out  = net_data_q;
  assign net_valid_out = net_valid_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign err_timeout   = err_q;
  assign drop_count    = drop_q;
`ifdef LOCAL_LOOPBACK_EN
  assign lb_data_out   = lb_data_q;
  assign lb_valid_out  = lb_valid_q;
`else
  assign lb_data_out   = '0;
  assign lb_valid_out  = 1'b0;
`endif

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Directed bench for net_tx_arbiter: vector table plus timeout/reset/loopback
// sequences, built with TIMEOUT=4 and four requesters.
module tb_net_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rv;
  logic [63:0] rd;
  logic [3:0]  rr;
  logic [15:0] nd;
  logic        nv;
  logic        nr;
  logic [15:0] ld;
  logic        lv;
  logic        lr;
  logic [1:0]  gid;
  logic        bsy;
  logic        err;
  logic [15:0] dc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  net_tx_arbiter #(
    .GPU_ID (22),
    .N_REQ  (4),
    .TIMEOUT(4)
  ) dut (
    .ACLK         (clk),
    .ARESETn      (rst_n),
    .req_valid    (rv),
    .req_data     (rd),
    .req_ready    (rr),
    .net_data_out (nd),
    .net_valid_out(nv),
    .net_ready_in (nr),
    .lb_data_out  (ld),
    .lb_valid_out (lv),
    .lb_ready_in  (lr),
    .grant_id     (gid),
    .busy         (bsy),
    .err_timeout  (err),
    .drop_count   (dc)
  );

  typedef struct {
    logic [3:0]  rv;
    logic        nr;
    logic [3:0]  rr;
    logic        nv;
    logic [15:0] nd;
    logic [1:0]  g;
    logic        b;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0, 1'b0};
    vt[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 16'h5D23, 2'd0, 1'b1};
    vt[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 16'h5D23, 2'd0, 1'b0};
    vt[3]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 16'h1111, 2'd1, 1'b1};
    vt[4]  = '{4'b1111, 1'b1, 4'b0100, 1'b0, 16'h1111, 2'd1, 1'b0};
    vt[5]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 16'h2222, 2'd2, 1'b1};
    vt[6]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 16'h2222, 2'd2, 1'b0};
    vt[7]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 16'h3333, 2'd3, 1'b1};
    vt[8]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 16'h3333, 2'd3, 1'b0};
    vt[9]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 16'h5D23, 2'd0, 1'b1};
    vt[10] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 16'h5D23, 2'd0, 1'b0};
    vt[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 16'h2222, 2'd2, 1'b1};
    vt[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 16'h2222, 2'd2, 1'b1};
    vt[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h2222, 2'd2, 1'b0};

    rst_n = 1'b0;
    rv    = 4'b0000;
    rd    = {16'h3333, 16'h2222, 16'h1111, 16'h5D23};
    nr    = 1'b0;
    lr    = 1'b0;
    #2;
    chk("rst nv", 32'(nv), 32'd0);
    chk("rst nd", 32'(nd), 32'd0);
    chk("rst busy", 32'(bsy), 32'd0);
    chk("rst gid", 32'(gid), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst dc", 32'(dc), 32'd0);
    chk("rst lv", 32'(lv), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single packet, then full round robin with continuous requests.
    for (int i = 0; i < 14; i++) begin
      rv = vt[i].rv;
      nr = vt[i].nr;
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(rr), 32'(vt[i].rr));
      chk($sformatf("v%0d net_valid", i), 32'(nv), 32'(vt[i].nv));
      chk($sformatf("v%0d net_data", i), 32'(nd), 32'(vt[i].nd));
      chk($sformatf("v%0d grant_id", i), 32'(gid), 32'(vt[i].g));
      chk($sformatf("v%0d busy", i), 32'(bsy), 32'(vt[i].b));
      chk($sformatf("v%0d err", i), 32'(err), 32'd0);
      chk($sformatf("v%0d drop", i), 32'(dc), 32'd0);
      tick();
    end

    // Stall timeout: four ready-low cycles then drop.
    rv = 4'b0010;
    nr = 1'b0;
    #1;
    chk("to req_ready", 32'(rr), 32'b0010);
    tick();
    rv = 4'b0000;
    chk("to held", 32'(nv), 32'd1);
    chk("to gid", 32'(gid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("to stall%0d nv", k), 32'(nv), 32'd1);
      chk($sformatf("to stall%0d err", k), 32'(err), 32'd0);
    end
    tick();
    chk("to drop nv", 32'(nv), 32'd0);
    chk("to drop err", 32'(err), 32'd1);
    chk("to drop dc", 32'(dc), 32'd1);
    chk("to drop busy", 32'(bsy), 32'd0);
    tick();
    chk("to pulse end", 32'(err), 32'd0);
    rv = 4'b1111;
    #1;
    chk("to next req", 32'(rr), 32'b0100);

    // Accept on the exact timeout cycle.
    tick();
    rv = 4'b0000;
    chk("acc gid", 32'(gid), 32'd2);
    chk("acc nd", 32'(nd), 32'h2222);
    tick();
    tick();
    tick();
    chk("acc pre nv", 32'(nv), 32'd1);
    nr = 1'b1;
    tick();
    chk("acc nv", 32'(nv), 32'd0);
    chk("acc err", 32'(err), 32'd0);
    chk("acc dc", 32'(dc), 32'd1);
    tick();
    chk("acc err2", 32'(err), 32'd0);

    // Reset while holding a packet.
    rv = 4'b0010;
    nr = 1'b0;
    #1;
    chk("rh req_ready", 32'(rr), 32'b0010);
    tick();
    chk("rh held", 32'(nv), 32'd1);
    rv = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("rh nv", 32'(nv), 32'd0);
    chk("rh nd", 32'(nd), 32'd0);
    chk("rh busy", 32'(bsy), 32'd0);
    chk("rh gid", 32'(gid), 32'd0);
    chk("rh dc", 32'(dc), 32'd0);
    chk("rh err", 32'(err), 32'd0);
    chk("rh rr", 32'(rr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nr = 1'b1;
    #1;
    chk("rh restart", 32'(rr), 32'b0001);
    @(posedge clk);
    #1;
    rv = 4'b0000;
    chk("rh g0 nd", 32'(nd), 32'h5D23);
    chk("rh g0 gid", 32'(gid), 32'd0);
    tick();
    chk("rh g0 done", 32'(nv), 32'd0);

    // Packet addressed to this GPU.
    rd[63:48] = 16'h5800;
    rv = 4'b1000;
    nr = 1'b0;
    lr = 1'b1;
    tick();
    rv = 4'b0000;
    chk("lb gid", 32'(gid), 32'd3);
`ifdef LOCAL_LOOPBACK_EN
    chk("lb lv", 32'(lv), 32'd1);
    chk("lb ld", 32'(ld), 32'h5800);
    chk("lb nv", 32'(nv), 32'd0);
    tick();
    chk("lb accepted", 32'(lv), 32'd0);
    chk("lb nv2", 32'(nv), 32'd0);
    chk("lb busy", 32'(bsy), 32'd0);
`else
    chk("lb nv", 32'(nv), 32'd1);
    chk("lb nd", 32'(nd), 32'h5800);
    chk("lb lv", 32'(lv), 32'd0);
    chk("lb ld", 32'(ld), 32'd0);
    tick();
    chk("lb ignored", 32'(nv), 32'd1);
    nr = 1'b1;
    tick();
    chk("lb net done", 32'(nv), 32'd0);
    chk("lb busy", 32'(bsy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
